// File: rtl/puerta_pkg.sv
// rtl/puerta_pkg.sv - door state encodings and default timing shared with the timeout block
package puerta_pkg;

  localparam logic [1:0] EST_CERRADA  = 2'b00;
  localparam logic [1:0] EST_ABIERTA  = 2'b01;
  localparam logic [1:0] EST_ABRIENDO = 2'b10;
  localparam logic [1:0] EST_CERRANDO = 2'b11;

  localparam int T_MOVE_DEF     = 4;
  localparam int MAX_REOPEN_DEF = 3;

  typedef enum logic [1:0] {
    CERRADA  = EST_CERRADA,
    ABIERTA  = EST_ABIERTA,
    ABRIENDO = EST_ABRIENDO,
    CERRANDO = EST_CERRANDO
  } estado_e;

endpackage

// File: rtl/puerta_cnt.sv
// rtl/puerta_cnt.sv - loadable down-counter timing door travel
module puerta_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // load has priority so a reversal can retarget the counter mid-travel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/puerta_ctrl.sv
// rtl/puerta_ctrl.sv - elevator door FSM; REOPEN_LIMIT_EN enables the obstruction reopen limit
module puerta_ctrl
  import puerta_pkg::*;
#(
  parameter int T_MOVE     = T_MOVE_DEF,
  parameter int MAX_REOPEN = MAX_REOPEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abrir,
  input  logic       cerrar,
  input  logic       moviendo,
  input  logic       obstaculo,
  input  logic       timeout,
  output logic [1:0] estado,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       puertas_cerradas,
  output logic       falla,
  output logic       alarma
);

  localparam int            CW        = $clog2(T_MOVE);
  localparam logic [CW-1:0] LOAD_FULL = CW'(T_MOVE - 1);

  estado_e       state_q;
  estado_e       state_d;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_en;
  logic          obst_rev;
  logic          falla_q;

  puerta_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .value    (cnt),
    .zero     (cnt_zero)
  );

`ifdef REOPEN_LIMIT_EN
  localparam int RW = $clog2(MAX_REOPEN + 1);

  logic [RW-1:0] reopen_q;
  logic          at_limit;

  assign at_limit = (reopen_q == RW'(MAX_REOPEN));
  assign obst_rev = obstaculo && !at_limit;

  // obst_rev is already gated by at_limit, so the increment saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reopen_q <= '0;
    end else if (state_q == CERRANDO && state_d == CERRADA) begin
      reopen_q <= '0;
    end else if (state_q == CERRANDO && obst_rev) begin
      reopen_q <= reopen_q + RW'(1);
    end
  end

  assign alarma = at_limit;
`else
  assign obst_rev = obstaculo;
  assign alarma   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CERRADA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = LOAD_FULL;
    cnt_en       = 1'b0;
    case (state_q)
      CERRADA: begin
        if (abrir && !moviendo) begin
          state_d  = ABRIENDO;
          cnt_load = 1'b1;
        end
      end
      ABRIENDO: begin
        if (cnt_zero) begin
          state_d = ABIERTA;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ABIERTA: begin
        if ((timeout || cerrar) && !abrir && !obstaculo) begin
          state_d  = CERRANDO;
          cnt_load = 1'b1;
        end
      end
      CERRANDO: begin
        // reopening retraces exactly the distance already closed
        if (abrir || obst_rev) begin
          state_d      = ABRIENDO;
          cnt_load     = 1'b1;
          cnt_load_val = LOAD_FULL - cnt;
        end else if (cnt_zero) begin
          state_d = CERRADA;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = CERRADA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      falla_q <= 1'b0;
    end else if (moviendo && state_q != CERRADA) begin
      falla_q <= 1'b1;
    end
  end

  assign estado           = state_q;
  assign motor_abrir      = (state_q == ABRIENDO);
  assign motor_cerrar     = (state_q == CERRANDO);
  assign puertas_cerradas = (state_q == CERRADA);
  assign falla            = falla_q;

endmodule

// File: tb/tb_puerta_ctrl.sv
// tb/tb_puerta_ctrl.sv - directed self-checking bench for puerta_ctrl
module tb_puerta_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abrir = 1'b0;
  logic       cerrar = 1'b0;
  logic       moviendo = 1'b0;
  logic       obstaculo = 1'b0;
  logic       timeout = 1'b0;
  logic [1:0] estado;
  logic       motor_abrir;
  logic       motor_cerrar;
  logic       puertas_cerradas;
  logic       falla;
  logic       alarma;

  int tests = 0;
  int fails = 0;

  puerta_ctrl #(.T_MOVE(4), .MAX_REOPEN(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .abrir            (abrir),
    .cerrar           (cerrar),
    .moviendo         (moviendo),
    .obstaculo        (obstaculo),
    .timeout          (timeout),
    .estado           (estado),
    .motor_abrir      (motor_abrir),
    .motor_cerrar     (motor_cerrar),
    .puertas_cerradas (puertas_cerradas),
    .falla            (falla),
    .alarma           (alarma)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    abrir = 1'b0; cerrar = 1'b0; moviendo = 1'b0; obstaculo = 1'b0; timeout = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic open_door();
    abrir = 1'b1;
    step();
    abrir = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (estado !== 2'b00) begin fails++; $display("FAIL reset_estado got %b want 00", estado); end
    tests++;
    if ({motor_abrir, motor_cerrar, puertas_cerradas} !== 3'b001) begin
      fails++; $display("FAIL reset_outs got %b want 001", {motor_abrir, motor_cerrar, puertas_cerradas});
    end
    tests++;
    if ({falla, alarma} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {falla, alarma}); end
  endtask

  task automatic test_normal();
    abrir = 1'b1;
    step();
    abrir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (estado !== 2'b10 || motor_abrir !== 1'b1) begin
        fails++; $display("FAIL normal_abriendo[%0d] got %b/%b want 10/1", i, estado, motor_abrir);
      end
      step();
    end
    tests++;
    if (estado !== 2'b01) begin fails++; $display("FAIL normal_abierta got %b want 01", estado); end
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (estado !== 2'b11 || motor_cerrar !== 1'b1) begin
        fails++; $display("FAIL normal_cerrando[%0d] got %b/%b want 11/1", i, estado, motor_cerrar);
      end
      step();
    end
    tests++;
    if (estado !== 2'b00 || puertas_cerradas !== 1'b1) begin
      fails++; $display("FAIL normal_cerrada got %b/%b want 00/1", estado, puertas_cerradas);
    end
  endtask

  task automatic test_hold_open();
    open_door();
    abrir = 1'b1;
    timeout = 1'b1;
    repeat (3) step();
    tests++;
    if (estado !== 2'b01) begin fails++; $display("FAIL hold_abrir got %b want 01", estado); end
    abrir = 1'b0;
    obstaculo = 1'b1;
    repeat (2) step();
    tests++;
    if (estado !== 2'b01) begin fails++; $display("FAIL hold_obst got %b want 01", estado); end
    obstaculo = 1'b0;
    step();
    timeout = 1'b0;
    tests++;
    if (estado !== 2'b11) begin fails++; $display("FAIL hold_release got %b want 11", estado); end
    repeat (4) step();
    tests++;
    if (estado !== 2'b00) begin fails++; $display("FAIL hold_closed got %b want 00", estado); end
  endtask

  task automatic test_obstruction();
    open_door();
    cerrar = 1'b1;
    step();
    cerrar = 1'b0;
    step();
    tests++;
    if ({motor_abrir, motor_cerrar} !== 2'b01) begin
      fails++; $display("FAIL obst_pre got %b want 01", {motor_abrir, motor_cerrar});
    end
    obstaculo = 1'b1;
    step();
    obstaculo = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (estado !== 2'b10 || {motor_abrir, motor_cerrar} !== 2'b10) begin
        fails++; $display("FAIL obst_reopen[%0d] got %b/%b want 10/10", i, estado, {motor_abrir, motor_cerrar});
      end
      step();
    end
    tests++;
    if (estado !== 2'b01) begin fails++; $display("FAIL obst_abierta got %b want 01", estado); end
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    repeat (4) step();
    tests++;
    if (estado !== 2'b00) begin fails++; $display("FAIL obst_closed got %b want 00", estado); end
  endtask

  task automatic test_ignore_moving();
    moviendo = 1'b1;
    abrir = 1'b1;
    repeat (3) step();
    tests++;
    if (estado !== 2'b00) begin fails++; $display("FAIL moving_estado got %b want 00", estado); end
    tests++;
    if (falla !== 1'b0) begin fails++; $display("FAIL moving_falla got %b want 0", falla); end
    moviendo = 1'b0;
    abrir = 1'b0;
    step();
  endtask

  task automatic test_reopen_limit();
    do_reset();
    open_door();
    for (int r = 0; r < 3; r++) begin
      timeout = 1'b1;
      step();
      timeout = 1'b0;
      obstaculo = 1'b1;
      step();
      obstaculo = 1'b0;
      step();
      tests++;
      if (estado !== 2'b01) begin fails++; $display("FAIL limit_reopen[%0d] got %b want 01", r, estado); end
    end
    tests++;
`ifdef REOPEN_LIMIT_EN
    if (alarma !== 1'b1) begin fails++; $display("FAIL limit_alarma got %b want 1", alarma); end
`else
    if (alarma !== 1'b0) begin fails++; $display("FAIL limit_alarma got %b want 0", alarma); end
`endif
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    obstaculo = 1'b1;
    repeat (4) step();
    tests++;
`ifdef REOPEN_LIMIT_EN
    if (estado !== 2'b00) begin fails++; $display("FAIL limit_fourth got %b want 00", estado); end
`else
    if (estado !== 2'b01) begin fails++; $display("FAIL limit_fourth got %b want 01", estado); end
`endif
    tests++;
    if (alarma !== 1'b0) begin fails++; $display("FAIL limit_alarma_clear got %b want 0", alarma); end
    obstaculo = 1'b0;
    do_reset();
  endtask

  task automatic test_fault();
    open_door();
    moviendo = 1'b1;
    step();
    moviendo = 1'b0;
    tests++;
    if (falla !== 1'b1) begin fails++; $display("FAIL fault_set got %b want 1", falla); end
    repeat (3) step();
    tests++;
    if (falla !== 1'b1 || estado !== 2'b01) begin
      fails++; $display("FAIL fault_sticky got %b/%b want 1/01", falla, estado);
    end
    do_reset();
    tests++;
    if (falla !== 1'b0) begin fails++; $display("FAIL fault_clear got %b want 0", falla); end
  endtask

  task automatic test_async_reset();
    abrir = 1'b1;
    step();
    abrir = 1'b0;
    step();
    tests++;
    if (estado !== 2'b10) begin fails++; $display("FAIL areset_pre got %b want 10", estado); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (estado !== 2'b00 || {motor_abrir, motor_cerrar} !== 2'b00) begin
      fails++; $display("FAIL areset_now got %b/%b want 00/00", estado, {motor_abrir, motor_cerrar});
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if (estado !== 2'b00) begin fails++; $display("FAIL areset_after got %b want 00", estado); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hold_open();
    test_obstruction();
    test_ignore_moving();
    test_reopen_limit();
    test_fault();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
